// File: rtl/cphy_esc_pkg.sv
// Shared C-PHY escape-mode definitions for the TX serializer and RX deserializer.
package cphy_esc_pkg;

  localparam int unsigned ESC_BYTE_W    = 8;
  localparam int unsigned ESC_BIT_CNT_W = $clog2(ESC_BYTE_W);

  typedef enum logic {
    ESC_SER_IDLE  = 1'b0,
    ESC_SER_SHIFT = 1'b1
  } esc_ser_state_e;

endpackage

// File: rtl/esc_serializer_if.sv
// Escape-mode byte handshake and serial line bundle; the serializer is the slave side.
interface esc_serializer_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] TxEscData;
  logic              TxValidEsc;
  logic              TxReadyEsc;
  logic              SerBit;
  logic              SerBitValid;
  logic              ByteDoneEsc;

  modport master (
    output TxEscData,
    output TxValidEsc,
    input  TxReadyEsc,
    input  SerBit,
    input  SerBitValid,
    input  ByteDoneEsc
  );

  modport slave (
    input  TxEscData,
    input  TxValidEsc,
    output TxReadyEsc,
    output SerBit,
    output SerBitValid,
    output ByteDoneEsc
  );

endinterface

// File: rtl/esc_ser_hold_buf.sv
// One-entry valid/ready holding register placed in front of the escape serializer shifter.
module esc_ser_hold_buf
  import cphy_esc_pkg::*;
#(
  parameter int unsigned DATA_W = ESC_BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush) begin
      full_d = 1'b0;
      data_d = '0;
    end else if (in_valid && in_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (out_valid && out_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = !full_q;
  assign out_valid = full_q;
  assign out_data  = data_q;

endmodule

// File: rtl/esc_serializer.sv
// C-PHY escape-mode TX byte serializer, LSB first, one bit per TxClkEsc cycle.
// Define ESC_SER_HOLD_EN to add a one-entry holding register ahead of the shifter.
module esc_serializer
  import cphy_esc_pkg::*;
#(
  parameter int unsigned DATA_W = ESC_BYTE_W
) (
  input  logic             TxClkEsc,
  input  logic             RstN,
  input  logic             EscSerEn,
  esc_serializer_if.slave  bus
);

  localparam int unsigned            CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(DATA_W - 1);

  esc_ser_state_e    state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ser_bit_q, ser_bit_d;
  logic              ser_valid_q, ser_valid_d;
  logic              byte_done_q, byte_done_d;

  logic              tx_ready;
  logic              accept;
  logic              last_bit;
  logic              load;
  logic [DATA_W-1:0] load_data;

  assign last_bit = (state_q == ESC_SER_SHIFT) && (bit_cnt_q == LAST_CNT);
  assign accept   = bus.TxValidEsc && tx_ready;

`ifdef ESC_SER_HOLD_EN
  logic              hold_full;
  logic              hold_in_ready;
  logic              from_hold;
  logic [DATA_W-1:0] hold_data;

  // Bytes accepted mid-byte park in the hold register; at the last bit the
  // shifter reloads from hold, or directly from the bus if hold is empty.
  esc_ser_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .clk       (TxClkEsc),
    .rst_n     (RstN),
    .flush     (!EscSerEn),
    .in_valid  (accept && (state_q == ESC_SER_SHIFT) && !last_bit),
    .in_ready  (hold_in_ready),
    .in_data   (bus.TxEscData),
    .out_valid (hold_full),
    .out_ready (from_hold),
    .out_data  (hold_data)
  );

  assign tx_ready  = RstN && EscSerEn && hold_in_ready;
  assign from_hold = EscSerEn && last_bit && hold_full;
  assign load      = from_hold || (accept && ((state_q == ESC_SER_IDLE) || last_bit));
  assign load_data = from_hold ? hold_data : bus.TxEscData;
`else
  assign tx_ready  = RstN && EscSerEn && ((state_q == ESC_SER_IDLE) || last_bit);
  assign load      = accept;
  assign load_data = bus.TxEscData;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = ser_valid_q;
    if (!EscSerEn) begin
      state_d     = ESC_SER_IDLE;
      bit_cnt_d   = '0;
      shift_d     = '0;
      ser_bit_d   = 1'b0;
      ser_valid_d = 1'b0;
    end else if (load) begin
      state_d     = ESC_SER_SHIFT;
      bit_cnt_d   = '0;
      shift_d     = load_data >> 1;
      ser_bit_d   = load_data[0];
      ser_valid_d = 1'b1;
    end else if (state_q == ESC_SER_SHIFT) begin
      if (last_bit) begin
        state_d     = ESC_SER_IDLE;
        bit_cnt_d   = '0;
        shift_d     = '0;
        ser_bit_d   = 1'b0;
        ser_valid_d = 1'b0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        shift_d   = shift_q >> 1;
        ser_bit_d = shift_q[0];
      end
    end
    // Registered pulse aligned with the MSB being on the line.
    byte_done_d = (state_d == ESC_SER_SHIFT) && (bit_cnt_d == LAST_CNT);
  end

  always_ff @(posedge TxClkEsc or negedge RstN) begin
    if (!RstN) begin
      state_q     <= ESC_SER_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign bus.TxReadyEsc  = tx_ready;
  assign bus.SerBit      = ser_bit_q;
  assign bus.SerBitValid = ser_valid_q;
  assign bus.ByteDoneEsc = byte_done_q;

endmodule

// File: tb/tb_esc_serializer.sv
// Directed scoreboard bench for esc_serializer: expected bits queued at accept, checked on the line.
module tb_esc_serializer;
  import cphy_esc_pkg::*;

  localparam int unsigned DATA_W = ESC_BYTE_W;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  esc_serializer_if #(.DATA_W(DATA_W)) bus ();

  esc_serializer #(.DATA_W(DATA_W)) dut (
    .TxClkEsc (clk),
    .RstN     (rst_n),
    .EscSerEn (en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int vcount, first_cyc, last_cyc, ndone;
  logic [1:0] sb [$];  // {byte_done, ser_bit}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clr();
    vcount    = 0;
    first_cyc = -1;
    last_cyc  = -1;
    ndone     = 0;
  endtask

  // Line monitor: every valid bit must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    logic [1:0] e;
    if (bus.SerBitValid === 1'b1) begin
      check("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ser_bit", 32'(bus.SerBit), 32'(e[0]));
        check("byte_done", 32'(bus.ByteDoneEsc), 32'(e[1]));
      end
      if (vcount == 0) first_cyc = cyc;
      last_cyc = cyc;
      vcount++;
      if (bus.ByteDoneEsc === 1'b1) ndone++;
    end else begin
      check("idle_ser_bit", 32'(bus.SerBit), 0);
      check("idle_done", 32'(bus.ByteDoneEsc), 0);
    end
  end

  // Offer a byte and hold it until accepted; queue the first nbits it should put on the line.
  task automatic offer(input logic [7:0] b, input int unsigned nbits, output int acc);
    logic [7:0] v;
    v = b;
    acc = -1;
    @(negedge clk);
    bus.TxEscData  = v;
    bus.TxValidEsc = 1'b1;
    #1;
    for (int i = 0; i < 40 && bus.TxReadyEsc !== 1'b1; i++) begin
      @(negedge clk);
      #1;
    end
    check("accept_ready", 32'(bus.TxReadyEsc), 1);
    if (bus.TxReadyEsc === 1'b1) begin
      for (int unsigned i = 0; i < nbits; i++)
        sb.push_back({(i == 7 && nbits == 8), v[i]});
      acc = cyc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.TxValidEsc = 1'b0;
    for (int i = 0; i < 60 && (sb.size() != 0 || bus.SerBitValid === 1'b1); i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_sb_empty", 32'(sb.size()), 0);
    check("drain_line_idle", 32'(bus.SerBitValid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2, a3;
    rst_n          = 1'b0;
    en             = 1'b0;
    bus.TxValidEsc = 1'b0;
    bus.TxEscData  = '0;
    clr();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ser_bit", 32'(bus.SerBit), 0);
    check("rst_ser_valid", 32'(bus.SerBitValid), 0);
    check("rst_byte_done", 32'(bus.ByteDoneEsc), 0);
    check("rst_ready", 32'(bus.TxReadyEsc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_ready_en0", 32'(bus.TxReadyEsc), 0);
    en = 1'b1;
    #1;
    check("idle_ready_en1", 32'(bus.TxReadyEsc), 1);

    // 1: single byte 0xA5
    clr();
    offer(8'hA5, 8, a1);
    drain();
    check("t1_count", vcount, 8);
    check("t1_span", last_cyc - first_cyc + 1, 8);
    check("t1_latency", first_cyc, a1);
    check("t1_done_cnt", ndone, 1);

    // 2: 0x01 then 0x80 back-to-back, no gap
    clr();
    offer(8'h01, 8, a1);
    offer(8'h80, 8, a2);
    drain();
    check("t2_count", vcount, 16);
    check("t2_span", last_cyc - first_cyc + 1, 16);
    check("t2_done_cnt", ndone, 2);
`ifdef ESC_SER_HOLD_EN
    check("t2_accept2_cyc", a2, a1 + 1);
`else
    check("t2_accept2_cyc", a2, a1 + 8);
`endif

    // 3: abort 0xFF after bit 3, then clean 0x3C
    clr();
    offer(8'hFF, 4, a1);
    repeat (4) @(negedge clk);
    en = 1'b0;
    #1;
    check("t3_ready_off", 32'(bus.TxReadyEsc), 0);
    drain();
    check("t3_abort_count", vcount, 4);
    check("t3_abort_done", ndone, 0);
    @(negedge clk);
    en = 1'b1;
    clr();
    offer(8'h3C, 8, a1);
    drain();
    check("t3_clean_count", vcount, 8);
    check("t3_clean_latency", first_cyc, a1);
    check("t3_clean_done", ndone, 1);

    // 4: async reset during bit 5 of 0x5A
    clr();
    offer(8'h5A, 6, a1);
    repeat (6) @(negedge clk);
    #2;
    bus.TxValidEsc = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t4_ser_bit", 32'(bus.SerBit), 0);
    check("t4_ser_valid", 32'(bus.SerBitValid), 0);
    check("t4_byte_done", 32'(bus.ByteDoneEsc), 0);
    check("t4_ready", 32'(bus.TxReadyEsc), 0);
    check("t4_sb_empty", 32'(sb.size()), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t4_ready_after", 32'(bus.TxReadyEsc), 1);

    // 5: valid with serializer disabled is ignored
    clr();
    @(negedge clk);
    en = 1'b0;
    bus.TxEscData  = 8'h77;
    bus.TxValidEsc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_ready_off", 32'(bus.TxReadyEsc), 0);
      @(negedge clk);
    end
    bus.TxValidEsc = 1'b0;
    en = 1'b1;
    #1;
    check("t5_ready_idle", 32'(bus.TxReadyEsc), 1);
    check("t5_nothing_sent", vcount, 0);

`ifdef ESC_SER_HOLD_EN
    // 6: three bytes through the hold register, 24 contiguous bits
    clr();
    offer(8'h11, 8, a1);
    offer(8'h22, 8, a2);
    @(negedge clk);
    #1;
    check("t6_hold_full_ready", 32'(bus.TxReadyEsc), 0);
    offer(8'h33, 8, a3);
    drain();
    check("t6_accept2_cyc", a2, a1 + 1);
    check("t6_accept3_cyc", a3, a1 + 9);
    check("t6_count", vcount, 24);
    check("t6_span", last_cyc - first_cyc + 1, 24);
    check("t6_done_cnt", ndone, 3);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
